// File: rtl/alu_rr_scheduler_pkg.sv
// rtl/alu_rr_scheduler_pkg.sv - shared constants, FSM encoding and grant helper for alu_rr_scheduler
package alu_rr_scheduler_pkg;

    // Default operand and operation-code widths; the ALU result is 2*D_S wide.
    localparam int DEF_D_S  = 8;
    localparam int DEF_OP_W = 4;

    // Scheduler FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    // Requester identifiers.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Round-robin pick between two requesters: a lone requester wins outright,
    // under contention the port that did not win last time goes next.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last_gnt);
        logic pick;
        if (v0 && v1) begin
            pick = ~last_gnt;
        end else if (v1) begin
            pick = PORT1;
        end else begin
            pick = PORT0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ALU_8bit.sv
// rtl/ALU_8bit.sv - combinational ALU, 16 operations, double-width result plus carry flag
module ALU_8bit #(
    parameter int D_S  = 8,
    parameter int OP_W = 4
) (
    input  logic [D_S-1:0]   A,
    input  logic [D_S-1:0]   B,
    input  logic [OP_W-1:0]  operation,
    output logic [2*D_S-1:0] result,
    output logic             carry_flag
);

    logic [D_S:0]     wide_sum;
    logic [D_S:0]     wide_diff;
    logic [2*D_S-1:0] ext_a;
    logic [2*D_S-1:0] ext_b;
    logic [2*D_S-1:0] product;

    assign wide_sum  = {1'b0, A} + {1'b0, B};
    assign wide_diff = {1'b0, A} - {1'b0, B};
    assign ext_a     = {{D_S{1'b0}}, A};
    assign ext_b     = {{D_S{1'b0}}, B};
    assign product   = ext_a * ext_b;

    // Operation decode; carry is the add carry, sub borrow, shifted-out bit,
    // high-half-nonzero for multiply and divide-by-zero for divide.
    always_comb begin
        result     = '0;
        carry_flag = 1'b0;
        case (operation)
            4'h0: begin
                result     = {{D_S{1'b0}}, wide_sum[D_S-1:0]};
                carry_flag = wide_sum[D_S];
            end
            4'h1: begin
                result     = {{D_S{1'b0}}, wide_diff[D_S-1:0]};
                carry_flag = wide_diff[D_S];
            end
            4'h2: begin
                result     = product;
                carry_flag = |product[2*D_S-1:D_S];
            end
            4'h3: begin
                if (B == '0) begin
                    result     = '0;
                    carry_flag = 1'b1;
                end else begin
                    result = {A % B, A / B};
                end
            end
            4'h4: begin
                result     = {{D_S{1'b0}}, A[D_S-2:0], 1'b0};
                carry_flag = A[D_S-1];
            end
            4'h5: begin
                result     = {{D_S{1'b0}}, 1'b0, A[D_S-1:1]};
                carry_flag = A[0];
            end
            4'h6: begin
                result     = {{D_S{1'b0}}, A[D_S-2:0], A[D_S-1]};
                carry_flag = A[D_S-1];
            end
            4'h7: begin
                result     = {{D_S{1'b0}}, A[0], A[D_S-1:1]};
                carry_flag = A[0];
            end
            4'h8: result = {{D_S{1'b0}}, A & B};
            4'h9: result = {{D_S{1'b0}}, A | B};
            4'hA: result = {{D_S{1'b0}}, A ^ B};
            4'hB: result = {{D_S{1'b0}}, ~(A | B)};
            4'hC: result = {{D_S{1'b0}}, ~(A & B)};
            4'hD: result = {{D_S{1'b0}}, ~(A ^ B)};
            4'hE: result = {{(2*D_S-1){1'b0}}, (A > B)};
            4'hF: result = {{(2*D_S-1){1'b0}}, (A == B)};
            default: begin
                result     = '0;
                carry_flag = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - two-port round-robin scheduler sharing one ALU_8bit
module alu_rr_scheduler
    import alu_rr_scheduler_pkg::*;
#(
    parameter int D_S  = DEF_D_S,
    parameter int OP_W = DEF_OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [D_S-1:0]   req0_a,
    input  logic [D_S-1:0]   req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [D_S-1:0]   req1_a,
    input  logic [D_S-1:0]   req1_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*D_S-1:0] out_result,
    output logic             out_carry,
    output logic             out_id,
    output logic             busy
);

    sched_state_t     state_q;
    logic             last_gnt_q;
    logic             cur_id_q;
    logic [OP_W-1:0]  op_q;
    logic [D_S-1:0]   a_q;
    logic [D_S-1:0]   b_q;
    logic             out_valid_q;
    logic [2*D_S-1:0] out_result_q;
    logic             out_carry_q;
    logic             out_id_q;

    logic             gnt_any;
    logic             gnt_id;
    logic [OP_W-1:0]  op_d;
    logic [D_S-1:0]   a_d;
    logic [D_S-1:0]   b_d;

    logic [2*D_S-1:0] alu_result;
    logic             alu_carry;

    // Grant only exists in IDLE and depends on request valids and last winner,
    // never on out_ready.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = PORT0;
        if ((state_q == IDLE) && (req0_valid || req1_valid)) begin
            gnt_any = 1'b1;
            gnt_id  = rr_pick(req0_valid, req1_valid, last_gnt_q);
        end
    end

    // Command presented by the granted port, latched on transfer.
    always_comb begin
        op_d = req0_op;
        a_d  = req0_a;
        b_d  = req0_b;
        if (gnt_id == PORT1) begin
            op_d = req1_op;
            a_d  = req1_a;
            b_d  = req1_b;
        end
    end

    assign req0_ready = gnt_any && (gnt_id == PORT0);
    assign req1_ready = gnt_any && (gnt_id == PORT1);

    // The shared ALU sees only latched operands so request-port changes
    // after acceptance cannot disturb the result being computed.
    ALU_8bit #(
        .D_S  (D_S),
        .OP_W (OP_W)
    ) u_alu (
        .A          (a_q),
        .B          (b_q),
        .operation  (op_q),
        .result     (alu_result),
        .carry_flag (alu_carry)
    );

    // Scheduler FSM: accept in IDLE, compute in EXEC, present result in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_gnt_q   <= PORT1;
            cur_id_q     <= PORT0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_carry_q  <= 1'b0;
            out_id_q     <= PORT0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        op_q       <= op_d;
                        a_q        <= a_d;
                        b_q        <= b_d;
                        cur_id_q   <= gnt_id;
                        last_gnt_q <= gnt_id;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    out_result_q <= alu_result;
                    out_carry_q  <= alu_carry;
                    out_id_q     <= cur_id_q;
                    out_valid_q  <= 1'b1;
                    state_q      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_carry  = out_carry_q;
    assign out_id     = out_id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - scoreboard bench for alu_rr_scheduler
module tb_alu_rr_scheduler;
    import alu_rr_scheduler_pkg::*;

    localparam int D_S  = DEF_D_S;
    localparam int OP_W = DEF_OP_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [OP_W-1:0]  req0_op, req1_op;
    logic [D_S-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic             out_valid, out_ready;
    logic [2*D_S-1:0] out_result;
    logic             out_carry, out_id, busy;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.D_S(D_S), .OP_W(OP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_id     (out_id),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Golden ALU fed by whichever port the bench expects to win.
    logic             m_last = 1'b1;
    logic             g_sel;
    logic [OP_W-1:0]  g_op;
    logic [D_S-1:0]   g_a, g_b;
    logic [2*D_S-1:0] g_result;
    logic             g_carry;

    assign g_sel = (req0_valid && req1_valid) ? ~m_last : req1_valid;
    assign g_op  = g_sel ? req1_op : req0_op;
    assign g_a   = g_sel ? req1_a  : req0_a;
    assign g_b   = g_sel ? req1_b  : req0_b;

    ALU_8bit #(.D_S(D_S), .OP_W(OP_W)) golden (
        .A          (g_a),
        .B          (g_b),
        .operation  (g_op),
        .result     (g_result),
        .carry_flag (g_carry)
    );

    typedef struct packed {
        logic             id;
        logic [2*D_S-1:0] res;
        logic             c;
    } exp_t;

    typedef enum {M_IDLE, M_EXEC, M_HOLD} mstate_t;

    exp_t    sb[$];
    logic    id_log[$];
    mstate_t m_st = M_IDLE;
    bit      m_chk_rst = 1'b0;

    // Cycle model: grant expectation, state-dependent outputs and scoreboard.
    initial begin
        logic e0, e1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_st      = M_IDLE;
                m_last    = 1'b1;
                sb.delete();
                m_chk_rst = 1'b1;
            end else begin
                if (m_chk_rst) begin
                    check("rst_result", 32'(out_result), 32'h0);
                    check("rst_carry", 32'(out_carry), 32'h0);
                    check("rst_id", 32'(out_id), 32'h0);
                    m_chk_rst = 1'b0;
                end
                case (m_st)
                    M_IDLE: begin
                        e0 = req0_valid && (!req1_valid || m_last);
                        e1 = req1_valid && (!req0_valid || !m_last);
                        check("idle_ready0", 32'(req0_ready), 32'(e0));
                        check("idle_ready1", 32'(req1_ready), 32'(e1));
                        check("idle_busy", 32'(busy), 32'h0);
                        check("idle_out_valid", 32'(out_valid), 32'h0);
                        if (e0 || e1) begin
                            e.id  = g_sel;
                            e.res = g_result;
                            e.c   = g_carry;
                            sb.push_back(e);
                            id_log.push_back(g_sel);
                            m_last = g_sel;
                            m_st   = M_EXEC;
                        end
                    end
                    M_EXEC: begin
                        check("exec_ready0", 32'(req0_ready), 32'h0);
                        check("exec_ready1", 32'(req1_ready), 32'h0);
                        check("exec_busy", 32'(busy), 32'h1);
                        check("exec_out_valid", 32'(out_valid), 32'h0);
                        m_st = M_HOLD;
                    end
                    M_HOLD: begin
                        check("hold_ready0", 32'(req0_ready), 32'h0);
                        check("hold_ready1", 32'(req1_ready), 32'h0);
                        check("hold_busy", 32'(busy), 32'h1);
                        check("hold_out_valid", 32'(out_valid), 32'h1);
                        check("hold_sb_nonempty", 32'(sb.size() > 0), 32'h1);
                        if (sb.size() > 0) begin
                            check("hold_result", 32'(out_result), 32'(sb[0].res));
                            check("hold_carry", 32'(out_carry), 32'(sb[0].c));
                            check("hold_id", 32'(out_id), 32'(sb[0].id));
                        end
                        if (out_ready) begin
                            if (sb.size() > 0) void'(sb.pop_front());
                            m_st = M_IDLE;
                        end
                    end
                    default: m_st = M_IDLE;
                endcase
            end
        end
    end

    task automatic issue(input logic port, input logic [OP_W-1:0] op,
                         input logic [D_S-1:0] a, input logic [D_S-1:0] b);
        bit got = 1'b0;
        if (port) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if ((port ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
        end
        check("issue_accepted", 32'(got), 32'h1);
        @(posedge clk); #1;
        if (port) req1_valid = 1'b0;
        else      req0_valid = 1'b0;
    endtask

    task automatic wait_idle(output int busy_cycles);
        bit done = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            else done = 1'b1;
        end
        check("idle_reached", 32'(done), 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic wait_out_valid();
        bit got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) got = 1'b1;
        end
        check("out_valid_seen", 32'(got), 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic wait_xfers(input int n);
        for (int i = 0; i < 96 && id_log.size() < n; i++) @(negedge clk);
        check("xfer_count_reached", 32'(id_log.size() >= n), 32'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        int bc;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single requester: 0x3C + 0x05.
        issue(1'b0, 4'd0, 8'h3C, 8'h05);
        wait_idle(bc);
        check("single_busy_cycles", 32'(bc), 32'd2);
        check("single_result", 32'(out_result), 32'h0041);
        check("single_carry", 32'(out_carry), 32'h0);
        check("single_id", 32'(out_id), 32'h0);

        // Contention from reset-state arbitration.
        id_log.delete();
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        req0_op = 4'd0; req0_a = 8'hFF; req0_b = 8'h01;
        req1_op = 4'd1; req1_a = 8'hFF; req1_b = 8'h01;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_xfers(3);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle(bc);
        check("cont_size", 32'(id_log.size()), 32'd3);
        if (id_log.size() >= 3) begin
            check("cont_id0", 32'(id_log[0]), 32'h0);
            check("cont_id1", 32'(id_log[1]), 32'h1);
            check("cont_id2", 32'(id_log[2]), 32'h0);
        end
        check("cont_last_result", 32'(out_result), 32'h0000);
        check("cont_last_carry", 32'(out_carry), 32'h1);

        // Backpressure with a port-1 command pending.
        id_log.delete();
        out_ready = 1'b0;
        issue(1'b0, 4'd2, 8'h12, 8'h34);
        wait_out_valid();
        req1_op = 4'd3; req1_a = 8'h9A; req1_b = 8'h0B; req1_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        issue(1'b1, 4'd3, 8'h9A, 8'h0B);
        out_ready = 1'b1;
        wait_idle(bc);
        check("bp_size", 32'(id_log.size()), 32'd2);
        if (id_log.size() >= 2) check("bp_second_id", 32'(id_log[1]), 32'h1);

        // Sweep all op codes on port 1.
        id_log.delete();
        for (int op = 0; op < 16; op++) begin
            issue(1'b1, OP_W'(op), D_S'($urandom), D_S'($urandom));
        end
        wait_idle(bc);
        check("sweep_size", 32'(id_log.size()), 32'd16);
        foreach (id_log[i]) check("sweep_id", 32'(id_log[i]), 32'h1);

        // Reset the cycle after acceptance.
        issue(1'b0, 4'd5, 8'h81, 8'h00);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstexec_out_valid", 32'(out_valid), 32'h0);
        check("rstexec_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        id_log.delete();
        req0_op = 4'd8; req0_a = 8'hF0; req0_b = 8'h3C;
        req1_op = 4'd9; req1_a = 8'h0F; req1_b = 8'h30;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_xfers(1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle(bc);
        if (id_log.size() >= 1) check("rstexec_first_id", 32'(id_log[0]), 32'h0);

        // Port 1 withdraws valid while the scheduler is holding a result.
        id_log.delete();
        out_ready = 1'b0;
        issue(1'b0, 4'd10, 8'hAA, 8'h0F);
        wait_out_valid();
        req1_op = 4'd0; req1_a = 8'h01; req1_b = 8'h02; req1_valid = 1'b1;
        @(posedge clk); #1 req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle(bc);
        repeat (3) @(posedge clk);
        #1;
        check("withdraw_size", 32'(id_log.size()), 32'd1);
        if (id_log.size() >= 1) check("withdraw_id", 32'(id_log[0]), 32'h0);
        check("withdraw_result", 32'(out_result), 32'h00A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1);
    end

endmodule
